// File: rtl/pixel_stream_sequencer_if.sv
// Bus bundle between the pixel stream sequencer, its image RAM and the kernel units.
// master: sequencer side (drives addresses/broadcast); slave: RAM/kernel/collector side.
// Signals: start, img_addr, img_rdata, pixel_position_or_address, data_out, we,
//          result_valid, busy, done, and hold when SEQ_HOLD_EN is defined.
interface pixel_stream_sequencer_if #(
    parameter int bitSize = 6
);
    logic             start;
    logic [bitSize:0] img_addr;
    logic [7:0]       img_rdata;
    logic [bitSize:0] pixel_position_or_address;
    logic [7:0]       data_out;
    logic             we;
    logic             result_valid;
    logic             busy;
    logic             done;
`ifdef SEQ_HOLD_EN
    logic             hold;

    modport master (
        input  start, img_rdata, hold,
        output img_addr, pixel_position_or_address, data_out,
        output we, result_valid, busy, done
    );
    modport slave (
        output start, img_rdata, hold,
        input  img_addr, pixel_position_or_address, data_out,
        input  we, result_valid, busy, done
    );
`else
    modport master (
        input  start, img_rdata,
        output img_addr, pixel_position_or_address, data_out,
        output we, result_valid, busy, done
    );
    modport slave (
        output start, img_rdata,
        input  img_addr, pixel_position_or_address, data_out,
        input  we, result_valid, busy, done
    );
`endif
endinterface

// File: rtl/pixel_stream_sequencer.sv
// Scans an N*N image RAM, broadcasting each pixel to the kernel units (LOAD), then
// sweeps the addresses again with we=0 and flags each result beat (READOUT).
// Ports: clk, rst (sync, active high), bus (pixel_stream_sequencer_if.master).
// Every address is held for a 2-cycle beat; beats start on cycles with beat_ph=0.
// Optional macro SEQ_HOLD_EN adds bus.hold, which stretches active beats by 2 cycles.
module pixel_stream_sequencer #(
    parameter int N       = 8,
    parameter int bitSize = 6
) (
    input logic                      clk,
    input logic                      rst,
    pixel_stream_sequencer_if.master bus
);
    localparam int               LAST_I = N * N - 1;
    localparam logic [bitSize:0] LAST   = LAST_I[bitSize:0];

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREFETCH = 3'd1,
        LOAD     = 3'd2,
        READOUT  = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state;
    state_t           nxt;
    logic             beat_ph;
    logic             active;
    logic             stall;
    logic             adv;
    logic             last;
    logic [bitSize:0] addr;
    logic [bitSize:0] addr_nxt;
    logic [bitSize:0] fetch;
    logic [7:0]       pix;

    assign active = (state == PREFETCH) || (state == LOAD) || (state == READOUT);

`ifdef SEQ_HOLD_EN
    // Hold is sampled in the first cycle of a beat; when set, the following
    // beat-start edge is skipped, stretching the beat by exactly two cycles.
    logic hold_q;

    always_ff @(posedge clk) begin
        if (rst) hold_q <= 1'b0;
        else     hold_q <= ~beat_ph & bus.hold & active;
    end

    assign stall = hold_q;
`else
    assign stall = 1'b0;
`endif

    // The edge that ends a beat_ph=1 cycle is the beat-start edge.
    assign adv = beat_ph & ~stall;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:     if (bus.start && beat_ph) nxt = PREFETCH;
            PREFETCH: if (adv)                  nxt = LOAD;
            LOAD:     if (adv && last)          nxt = READOUT;
            READOUT:  if (adv && last)          nxt = DONE;
            DONE:                               nxt = IDLE;
            default:                            nxt = IDLE;
        endcase
    end

    always_comb begin
        addr_nxt = '0;
        if ((state == LOAD || state == READOUT) && !last)
            addr_nxt = addr + 1'b1;
    end

    // fetch runs one pixel ahead of addr so the RAM word arrives in the 2nd
    // cycle of the beat and is captured into pix on the next beat start.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_ph <= 1'b0;
            addr    <= '0;
            last    <= 1'b0;
            fetch   <= '0;
            pix     <= '0;
        end else begin
            beat_ph <= ~beat_ph;
            if (adv) begin
                addr <= addr_nxt;
                // Registered terminal compare lines up with the beat-start edge.
                last <= (addr_nxt == LAST);
                unique case (state)
                    PREFETCH, LOAD: begin
                        pix <= bus.img_rdata;
                        if (fetch != LAST) fetch <= fetch + 1'b1;
                    end
                    READOUT: if (last) fetch <= '0;
                    default: fetch <= '0;
                endcase
            end
        end
    end

    assign bus.img_addr = fetch;

    always_comb begin
        bus.we                        = 1'b0;
        bus.pixel_position_or_address = '0;
        bus.data_out                  = '0;
        bus.result_valid              = 1'b0;
        bus.busy                      = (state != IDLE);
        bus.done                      = 1'b0;
        unique case (state)
            LOAD: begin
                bus.we                        = 1'b1;
                bus.pixel_position_or_address = addr;
                bus.data_out                  = pix;
            end
            READOUT: begin
                bus.pixel_position_or_address = addr;
                bus.result_valid              = adv;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_pixel_stream_sequencer.sv
// Self-checking bench for pixel_stream_sequencer (N=8): per-cycle compare against
// a beat-list reference, spot-check vector table, RAM and 3x3 min-kernel stand-ins.
module tb_pixel_stream_sequencer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pixel_stream_sequencer_if #(.bitSize(6)) bus ();

    pixel_stream_sequencer #(.N(8), .bitSize(6)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef SEQ_HOLD_EN
    logic hold_drv = 1'b0;
    assign bus.hold = hold_drv;
`endif

    logic [7:0] mem  [64];
    logic [7:0] kmem [64];

    always @(posedge clk) bus.img_rdata <= mem[bus.img_addr[5:0]];

    always @(posedge clk)
        if (bus.we) kmem[bus.pixel_position_or_address[5:0]] <= bus.data_out;

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] data;
        logic       rv;
        logic       busy;
        logic       done;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t exp;
    } probe_t;

    obs_t   expq[$];
    obs_t   obs_log [300];
    probe_t probes  [11];
    int     n_checks = 0;
    int     n_pass   = 0;

    task automatic chk(input string nm, input int c,
                       input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, c, got, exp);
    endtask

    function automatic obs_t get_obs();
        obs_t o;
        o.we   = bus.we;
        o.addr = bus.pixel_position_or_address;
        o.data = bus.data_out;
        o.rv   = bus.result_valid;
        o.busy = bus.busy;
        o.done = bus.done;
        return o;
    endfunction

    function automatic obs_t mk(input logic we, input int a, input int d,
                                input logic rv, input logic bz, input logic dn);
        obs_t o;
        o.we   = we;
        o.addr = 7'(a);
        o.data = 8'(d);
        o.rv   = rv;
        o.busy = bz;
        o.done = dn;
        return o;
    endfunction

    // Expected pass as a list of beats: prefetch, 64 load, 64 readout, done, idle.
    function automatic void build(input int hold_beat, input int hold_len);
        int len;
        expq.delete();
        repeat (2) expq.push_back(mk(0, 0, 0, 0, 1, 0));
        for (int k = 0; k < 64; k++)
            repeat (2) expq.push_back(mk(1, k, mem[k], 0, 1, 0));
        for (int k = 0; k < 64; k++) begin
            len = 2 + ((k == hold_beat) ? 2 * ((hold_len + 1) / 2) : 0);
            for (int j = 0; j < len; j++)
                expq.push_back(mk(0, k, 0, j == len - 1, 1, 0));
        end
        expq.push_back(mk(0, 0, 0, 0, 1, 1));
        expq.push_back(mk(0, 0, 0, 0, 0, 0));
    endfunction

    function automatic logic [7:0] kres(input int a);
        logic [7:0] m = 8'hff;
        int r = a / 8;
        int c = a % 8;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                if (r + dr >= 0 && r + dr < 8 && c + dc >= 0 && c + dc < 8)
                    if (kmem[(r + dr) * 8 + c + dc] < m)
                        m = kmem[(r + dr) * 8 + c + dc];
        return m;
    endfunction

    function automatic logic [7:0] kexp(input int a);
        int r = a / 8;
        int c = a % 8;
        return (r >= 2 && r <= 4 && c >= 2 && c <= 4) ? 8'd0 : 8'd200;
    endfunction

    task automatic run_pass(input int hold_beat, input int hold_len,
                            input int restart_k, input int rst_k,
                            input bit kcheck);
        int   nw;
        int   limit;
        int   hs;
        obs_t o;
        build(hold_beat, hold_len);
        hs    = 2 + 128 + 2 * hold_beat;
        limit = (rst_k >= 0) ? 2 + 2 * rst_k + 1 : expq.size();
        bus.start = 1'b1;
        nw = 0;
        do begin
            @(negedge clk);
            nw++;
        end while (!bus.busy && nw < 4);
        chk("start_accept", nw, 32'(bus.busy && nw <= 2), 1);
        for (int c = 0; c < limit; c++) begin
            o = get_obs();
            obs_log[c] = o;
            chk("stream", c, 32'(o), 32'(expq[c]));
            if (kcheck && o.rv)
                chk("kernel", c, 32'(kres(int'(o.addr))), 32'(kexp(int'(o.addr))));
            bus.start = (restart_k >= 0) &&
                        (c == 2 + 2 * restart_k || c == 3 + 2 * restart_k);
            rst = (rst_k >= 0) && (c == 2 + 2 * rst_k);
`ifdef SEQ_HOLD_EN
            hold_drv = (hold_beat >= 0) && (c >= hs) && (c < hs + hold_len);
`endif
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (rst_k >= 0) begin
            rst = 1'b0;
            chk("rst_clear", 0, {13'd0, bus.img_addr, get_obs()}, 0);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                chk("no_done_after_rst", i, {bus.done, bus.busy}, 0);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        probes[0]  = '{0,   mk(0, 0,  0,  0, 1, 0)};
        probes[1]  = '{1,   mk(0, 0,  0,  0, 1, 0)};
        probes[2]  = '{2,   mk(1, 0,  0,  0, 1, 0)};
        probes[3]  = '{4,   mk(1, 1,  1,  0, 1, 0)};
        probes[4]  = '{5,   mk(1, 1,  1,  0, 1, 0)};
        probes[5]  = '{129, mk(1, 63, 63, 0, 1, 0)};
        probes[6]  = '{130, mk(0, 0,  0,  0, 1, 0)};
        probes[7]  = '{131, mk(0, 0,  0,  1, 1, 0)};
        probes[8]  = '{257, mk(0, 63, 0,  1, 1, 0)};
        probes[9]  = '{258, mk(0, 0,  0,  0, 1, 1)};
        probes[10] = '{259, mk(0, 0,  0,  0, 0, 0)};

        rst = 1'b1;
        bus.start = 1'b0;
        for (int k = 0; k < 64; k++) mem[k] = 8'(k);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle", i, {13'd0, bus.img_addr, get_obs()}, 0);
        end

        run_pass(-1, 0, -1, -1, 0);
        for (int i = 0; i < 11; i++)
            chk("probe", probes[i].cyc, 32'(obs_log[probes[i].cyc]),
                32'(probes[i].exp));

        run_pass(-1, 0, 20, -1, 0);

        run_pass(-1, 0, -1, 30, 0);
        run_pass(-1, 0, -1, -1, 0);

        for (int k = 0; k < 64; k++) mem[k] = 8'd200;
        mem[27] = 8'd0;
        run_pass(-1, 0, -1, -1, 1);

        for (int t = 0; t < 3; t++) begin
            for (int k = 0; k < 64; k++) mem[k] = 8'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_pass(-1, 0, -1, -1, 0);
        end

`ifdef SEQ_HOLD_EN
        for (int k = 0; k < 64; k++) mem[k] = 8'(k);
        run_pass(10, 6, -1, -1, 0);
        chk("hold_total", 264, {obs_log[264].done, obs_log[263].done}, 2'b10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
